// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, RV32I decode constants and the issue payload.
// The ALU_* codes are also consumed by the ALU itself.
package alu_pkg;

  localparam int unsigned XLEN_W = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN_W-1:0] op1;
    logic [XLEN_W-1:0] op2;
    logic [3:0]        alu_ctrl;
    logic [4:0]        rd;
    logic              rd_we;
    logic              illegal;
  } alu_issue_t;

  localparam int unsigned ALU_ISSUE_W = $bits(alu_issue_t);

  // funct3 to ALU code for the base (funct7 = 0) encodings
  function automatic logic [3:0] f3_to_ctrl(input logic [2:0] f3);
    logic [3:0] ctrl;
    case (f3)
      F3_ADD:  ctrl = ALU_ADD;
      F3_SLL:  ctrl = ALU_SLL;
      F3_SLT:  ctrl = ALU_SLT;
      F3_SLTU: ctrl = ALU_SLTU;
      F3_XOR:  ctrl = ALU_XOR;
      F3_SR:   ctrl = ALU_SRL;
      F3_OR:   ctrl = ALU_OR;
      F3_AND:  ctrl = ALU_AND;
      default: ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_issue_stage_skid.sv
// Generic WIDTH-bit valid/ready register stage; 2-entry skid so upstream ready is a flop,
// or a single register with combinational ready when SKID_EN is 0.
module skid_buffer #(
  parameter int unsigned WIDTH   = 8,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} skid_state_e;

  skid_state_e      r_state;
  logic             r_valid;
  logic             r_ready;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_skid;
  logic             w_accept;
  logic             w_emit;

  generate
    if (SKID_EN) begin : g_skid
      assign o_ready = r_ready;
    end else begin : g_single
      assign o_ready = !r_valid || i_ready;
    end
  endgenerate

  assign w_accept = i_valid && o_ready;
  assign w_emit   = r_valid && i_ready;
  assign o_valid  = r_valid;
  assign o_data   = r_data;

  // Flush overrides any accept in the same cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_data  <= '0;
      r_skid  <= '0;
    end else if (i_flush) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_emit) begin
            r_data <= i_data;
          end else if (w_accept) begin
            r_skid  <= i_data;
            r_ready <= 1'b0;
            r_state <= S_FULL;
          end else if (w_emit) begin
            r_valid <= 1'b0;
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_emit) begin
            r_data  <= r_skid;
            r_ready <= 1'b1;
            r_state <= S_ONE;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute stage: decodes RV32I ALU instructions into operands and an ALU code,
// then registers the payload behind a valid/ready skid buffer.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_inst_valid,
  output logic            o_inst_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_rdata,
  input  logic [XLEN-1:0] i_rs2_rdata,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_op1,
  output logic [XLEN-1:0] o_op2,
  output logic [3:0]      o_alu_ctrl,
  output logic [4:0]      o_rd,
  output logic            o_rd_we,
  output logic            o_illegal
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic [31:0] w_shamt;
  logic        w_unused_rs1;
  logic        w_legal;
  alu_issue_t  w_dec;
  alu_issue_t  w_out;

  assign w_opcode     = i_inst[6:0];
  assign w_rd         = i_inst[11:7];
  assign w_f3         = i_inst[14:12];
  assign w_f7         = i_inst[31:25];
  assign w_imm_i      = 32'($signed(i_inst[31:20]));
  assign w_imm_u      = {i_inst[31:12], 12'h000};
  assign w_shamt      = 32'(i_inst[24:20]);
  assign w_unused_rs1 = ^i_inst[19:15];

  // Illegal encodings collapse to a zero-operand ADD with writeback disabled
  always_comb begin
    w_dec    = '0;
    w_legal  = 1'b0;
    w_dec.rd = w_rd;
    case (w_opcode)
      OPC_OP: begin
        w_dec.op1 = i_rs1_rdata;
        w_dec.op2 = i_rs2_rdata;
        if (w_f7 == F7_BASE) begin
          w_legal        = 1'b1;
          w_dec.alu_ctrl = f3_to_ctrl(w_f3);
        end else if (w_f7 == F7_ALT && w_f3 == F3_ADD) begin
          w_legal        = 1'b1;
          w_dec.alu_ctrl = ALU_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == F3_SR) begin
          w_legal        = 1'b1;
          w_dec.alu_ctrl = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        w_dec.op1      = i_rs1_rdata;
        w_dec.op2      = w_imm_i;
        w_dec.alu_ctrl = f3_to_ctrl(w_f3);
        w_legal        = 1'b1;
        if (w_f3 == F3_SLL) begin
          w_dec.op2 = w_shamt;
          w_legal   = (w_f7 == F7_BASE);
        end else if (w_f3 == F3_SR) begin
          w_dec.op2 = w_shamt;
          if (w_f7 == F7_ALT) begin
            w_dec.alu_ctrl = ALU_SRA;
          end else if (w_f7 != F7_BASE) begin
            w_legal = 1'b0;
          end
        end
      end
      OPC_LUI: begin
        w_legal   = 1'b1;
        w_dec.op2 = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal   = 1'b1;
        w_dec.op1 = i_pc;
        w_dec.op2 = w_imm_u;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_dec.op1      = '0;
      w_dec.op2      = '0;
      w_dec.alu_ctrl = ALU_ADD;
    end
    w_dec.illegal = !w_legal;
    w_dec.rd_we   = w_legal && (w_rd != 5'd0);
  end

  skid_buffer #(
    .WIDTH   (ALU_ISSUE_W),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_inst_valid),
    .o_ready (o_inst_ready),
    .i_data  (w_dec),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (w_out)
  );

  assign o_op1      = w_out.op1;
  assign o_op2      = w_out.op2;
  assign o_alu_ctrl = w_out.alu_ctrl;
  assign o_rd       = w_out.rd;
  assign o_rd_we    = w_out.rd_we;
  assign o_illegal  = w_out.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed spec vectors, skid/flush/reset scenarios,
// then random traffic checked against a field-level reference decoder.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush, i_inst_valid, o_inst_ready, o_valid, i_ready;
  logic [31:0] i_inst, i_pc, i_rs1_rdata, i_rs2_rdata, o_op1, o_op2;
  logic [3:0]  o_alu_ctrl;
  logic [4:0]  o_rd;
  logic        o_rd_we, o_illegal;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (i_flush),
    .i_inst_valid (i_inst_valid),
    .o_inst_ready (o_inst_ready),
    .i_inst       (i_inst),
    .i_pc         (i_pc),
    .i_rs1_rdata  (i_rs1_rdata),
    .i_rs2_rdata  (i_rs2_rdata),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_op1        (o_op1),
    .o_op2        (o_op2),
    .o_alu_ctrl   (o_alu_ctrl),
    .o_rd         (o_rd),
    .o_rd_we      (o_rd_we),
    .o_illegal    (o_illegal)
  );

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   emitted = 0;

  // ALU code for each funct3 in its base form; the alternate form (SUB/SRA) is code+1
  localparam logic [3:0] F3CODE [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};

  function automatic exp_t ref_model(input logic [31:0] inst, pc, a, b);
    exp_t        e;
    logic        ok;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_u, shamt;
    f7    = inst[31:25];
    f3    = inst[14:12];
    imm_i = 32'($signed(inst[31:20]));
    imm_u = {inst[31:12], 12'h000};
    shamt = 32'(inst[24:20]);
    e     = '0;
    ok    = 1'b0;
    case (inst[6:0])
      7'h33: begin
        e.op1 = a; e.op2 = b; e.ctrl = F3CODE[f3];
        if (f7 == 7'h00) ok = 1'b1;
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          ok = 1'b1; e.ctrl = e.ctrl + 4'd1;
        end
      end
      7'h13: begin
        e.op1 = a; e.op2 = imm_i; e.ctrl = F3CODE[f3]; ok = 1'b1;
        if (f3 == 3'd1) begin ok = (f7 == 7'h00); e.op2 = shamt; end
        if (f3 == 3'd5) begin
          e.op2 = shamt;
          ok = (f7 == 7'h00) || (f7 == 7'h20);
          if (f7 == 7'h20) e.ctrl = e.ctrl + 4'd1;
        end
      end
      7'h37: begin ok = 1'b1; e.op2 = imm_u; end
      7'h17: begin ok = 1'b1; e.op1 = pc; e.op2 = imm_u; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin e.op1 = '0; e.op2 = '0; e.ctrl = '0; end
    e.rd  = inst[11:7];
    e.we  = ok && (inst[11:7] != 5'd0);
    e.ill = !ok;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, pc, a, b,
                       input logic rdy, input logic fl);
    @(negedge clk);
    i_inst_valid = v; i_inst = inst; i_pc = pc;
    i_rs1_rdata = a; i_rs2_rdata = b; i_ready = rdy; i_flush = fl;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  // Monitor: mid-cycle, record what the next edge accepts and check what it emits
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (o_valid && i_ready) begin
        exp_t got, e;
        got = {o_op1, o_op2, o_alu_ctrl, o_rd, o_rd_we, o_illegal};
        checks++;
        emitted++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h expected none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL payload: got op1=%h op2=%h ctrl=%h rd=%0d we=%b ill=%b expected op1=%h op2=%h ctrl=%h rd=%0d we=%b ill=%b",
                     got.op1, got.op2, got.ctrl, got.rd, got.we, got.ill,
                     e.op1, e.op2, e.ctrl, e.rd, e.we, e.ill);
          end
        end
      end
      if (i_flush) q.delete();
      else if (i_inst_valid && o_inst_ready)
        q.push_back(ref_model(i_inst, i_pc, i_rs1_rdata, i_rs2_rdata));
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [31:0] inst;
    logic [6:0]  opc, f7;
    case ($urandom % 5)
      0: opc = 7'h33;
      1: opc = 7'h13;
      2: opc = 7'h37;
      3: opc = 7'h17;
      default: opc = 7'($urandom);
    endcase
    case ($urandom % 4)
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    inst      = {f7, 25'($urandom)};
    inst[6:0] = opc;
    return inst;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst = 1'b1; i_flush = 1'b0; i_inst_valid = 1'b0; i_ready = 1'b0;
    i_inst = '0; i_pc = '0; i_rs1_rdata = '0; i_rs2_rdata = '0;
    #12;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_inst_ready), 32'd1);
    chk("rst_op1", o_op1, 32'd0);
    chk("rst_op2", o_op2, 32'd0);
    chk("rst_ctrl", 32'(o_alu_ctrl), 32'd0);
    chk("rst_rd", 32'(o_rd), 32'd0);
    chk("rst_we", 32'(o_rd_we), 32'd0);
    chk("rst_ill", 32'(o_illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADDI x1,x0,-1 with one-cycle latency
    drive(1'b1, 32'hFFF00093, 32'h0, 32'h10, 32'h0, 1'b1, 1'b0);
    #1 chk("empty_no_valid", 32'(o_valid), 32'd0);
    idle(1'b1);
    #1;
    chk("latency1_valid", 32'(o_valid), 32'd1);
    chk("addi_op1", o_op1, 32'h10);
    chk("addi_op2", o_op2, 32'hFFFFFFFF);
    chk("addi_ctrl", 32'(o_alu_ctrl), 32'd0);
    chk("addi_rd_we", {27'd0, o_rd}, 32'd1);

    drive(1'b1, 32'h402081B3, 32'h0, 32'd7, 32'd9, 1'b1, 1'b0);
    drive(1'b1, 32'h40435293, 32'h0, 32'h80000000, 32'd0, 1'b1, 1'b0);
    #1 chk("sub_ctrl", 32'(o_alu_ctrl), 32'd1);
    drive(1'b1, 32'h123453B7, 32'h0, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
    #1 chk("srai_ctrl", 32'(o_alu_ctrl), 32'd7);
    drive(1'b1, 32'h12345397, 32'h100, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
    #1 chk("lui_op2", o_op2, 32'h12345000);
    drive(1'b1, 32'h02208133, 32'h0, 32'd5, 32'd6, 1'b1, 1'b0);
    #1 chk("auipc_op1", o_op1, 32'h100);
    idle(1'b1);
    #1;
    chk("mul_illegal", 32'(o_illegal), 32'd1);
    chk("mul_we", 32'(o_rd_we), 32'd0);
    chk("mul_op1", o_op1, 32'd0);
    idle(1'b1);

    // Skid: A,B fill the buffer, C is held until the output drains
    e0 = emitted;
    drive(1'b1, 32'h00100093, 32'h0, 32'd1, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 32'h00200113, 32'h0, 32'd2, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 32'h00300193, 32'h0, 32'd3, 32'd0, 1'b0, 1'b0);
    #1 chk("full_ready", 32'(o_inst_ready), 32'd0);
    drive(1'b1, 32'h00300193, 32'h0, 32'd3, 32'd0, 1'b1, 1'b0);
    drive(1'b1, 32'h00300193, 32'h0, 32'd3, 32'd0, 1'b1, 1'b0);
    repeat (4) idle(1'b1);
    chk("skid_emit_count", 32'(emitted - e0), 32'd3);

    // Flush in FULL with a valid input
    drive(1'b1, 32'h00100093, 32'h0, 32'd1, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 32'h00200113, 32'h0, 32'd2, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 32'h00300193, 32'h0, 32'd3, 32'd0, 1'b0, 1'b1);
    #1 chk("flush_pre_full", 32'(o_inst_ready), 32'd0);
    e0 = emitted;
    idle(1'b1);
    #1;
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_ready", 32'(o_inst_ready), 32'd1);
    repeat (3) idle(1'b1);
    chk("flush_emit_count", 32'(emitted - e0), 32'd0);

    // Random traffic with an asynchronous reset mid-stream
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_ready", 32'(o_inst_ready), 32'd1);
        chk("arst_op2", o_op2, 32'd0);
        chk("arst_we", 32'(o_rd_we), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
      end
      drive(($urandom % 4) != 0, rand_inst(), $urandom, $urandom, $urandom,
            ($urandom % 3) != 0, 1'b0);
    end

    for (int k = 0; k < 20 && q.size() != 0; k++) idle(1'b1);
    chk("drain_empty", 32'(q.size()), 32'd0);
    idle(1'b1);
    #1 chk("final_idle", 32'(o_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
